// File: rtl/mult16_sequencer_if.sv
// rtl/mult16_sequencer_if.sv - operand/result handshake and byte-multiplier port bundle
// master: operand source plus external 8x8 multiplier; slave: the sequencer.
interface mult16_sequencer_if;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_p;
  logic [31:0] product;
  logic        busy;
  logic        done;

  modport master (
    output start, op_a, op_b, mul_p,
    input  mul_a, mul_b, product, busy, done
  );

  modport slave (
    input  start, op_a, op_b, mul_p,
    output mul_a, mul_b, product, busy, done
  );
endinterface

// File: rtl/mult16_sequencer.sv
// rtl/mult16_sequencer.sv - 16x16 unsigned multiply over four cycles of a shared 8x8 multiplier
// Partial products are accumulated at 32 bits; the final sum is published on entry to DONE.
module mult16_sequencer #(
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  mult16_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PP0,
    S_PP1,
    S_PP2,
    S_PP3,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [31:0] r_acc;
  logic [31:0] r_product;

  logic        w_accept;
  logic        w_zero;
  logic        w_pp_state;
  logic [7:0]  w_mul_a;
  logic [7:0]  w_mul_b;
  logic [4:0]  w_shift;
  logic [31:0] w_pp;
  logic [31:0] w_acc_sum;

  // A new request is only taken when no partial product is in flight.
  always_comb begin
    w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start;
    w_zero   = EARLY_ZERO && ((bus.op_a == 16'd0) || (bus.op_b == 16'd0));
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_next_state = w_zero ? S_DONE : S_PP0;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_PP0:   w_next_state = S_PP1;
      S_PP1:   w_next_state = S_PP2;
      S_PP2:   w_next_state = S_PP3;
      S_PP3:   w_next_state = S_DONE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Byte selection and weight of each partial product.
  always_comb begin
    w_mul_a    = 8'd0;
    w_mul_b    = 8'd0;
    w_shift    = 5'd0;
    w_pp_state = 1'b1;
    case (r_state)
      S_PP0: begin
        w_mul_a = r_a[7:0];
        w_mul_b = r_b[7:0];
        w_shift = 5'd0;
      end
      S_PP1: begin
        w_mul_a = r_a[15:8];
        w_mul_b = r_b[7:0];
        w_shift = 5'd8;
      end
      S_PP2: begin
        w_mul_a = r_a[7:0];
        w_mul_b = r_b[15:8];
        w_shift = 5'd8;
      end
      S_PP3: begin
        w_mul_a = r_a[15:8];
        w_mul_b = r_b[15:8];
        w_shift = 5'd16;
      end
      default: w_pp_state = 1'b0;
    endcase
  end

  assign w_pp      = {16'd0, bus.mul_p} << w_shift;
  assign w_acc_sum = r_acc + w_pp;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_a       <= 16'd0;
      r_b       <= 16'd0;
      r_acc     <= 32'd0;
      r_product <= 32'd0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_a   <= bus.op_a;
        r_b   <= bus.op_b;
        r_acc <= 32'd0;
        if (w_zero) begin
          r_product <= 32'd0;
        end
      end else if (w_pp_state) begin
        r_acc <= w_acc_sum;
        // The last partial product goes straight into the result register.
        if (r_state == S_PP3) begin
          r_product <= w_acc_sum;
        end
      end
    end
  end

  assign bus.mul_a   = w_mul_a;
  assign bus.mul_b   = w_mul_b;
  assign bus.product = r_product;
  assign bus.busy    = w_pp_state;
  assign bus.done    = (r_state == S_DONE);

endmodule

// File: tb/tb_mult16_sequencer.sv
// tb/tb_mult16_sequencer.sv - testbench for mult16_sequencer
// Two instances (early-zero on and off) share stimulus; expected products come from plain a*b.
module tb_mult16_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mult16_sequencer_if ifz ();
  mult16_sequencer_if ifn ();

  assign ifz.mul_p = {8'd0, ifz.mul_a} * {8'd0, ifz.mul_b};
  assign ifn.mul_p = {8'd0, ifn.mul_a} * {8'd0, ifn.mul_b};

  mult16_sequencer #(.EARLY_ZERO(1'b1)) u_dut_ez (
    .clk   (clk),
    .reset (reset),
    .bus   (ifz.slave)
  );

  mult16_sequencer #(.EARLY_ZERO(1'b0)) u_dut_full (
    .clk   (clk),
    .reset (reset),
    .bus   (ifn.slave)
  );

  task automatic set_in(input logic s, input logic [15:0] a, input logic [15:0] b);
    ifz.start = s; ifz.op_a = a; ifz.op_b = b;
    ifn.start = s; ifn.op_a = a; ifn.op_b = b;
  endtask

  // Leaves the caller at the negedge of the first cycle after the accepting edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    set_in(1'b1, a, b);
    @(negedge clk);
    set_in(1'b0, a, b);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(1'b0, 16'd0, 16'd0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ifz.product !== 32'd0 || ifn.product !== 32'd0) begin
      n_err++; $display("FAIL reset_product got=%h/%h exp=0", ifz.product, ifn.product);
    end
    n_cmp++;
    if (ifz.busy !== 1'b0 || ifz.done !== 1'b0 || ifn.busy !== 1'b0 || ifn.done !== 1'b0) begin
      n_err++; $display("FAIL reset_flags got busy=%b done=%b exp 0/0", ifz.busy, ifz.done);
    end
    n_cmp++;
    if (ifz.mul_a !== 8'd0 || ifz.mul_b !== 8'd0) begin
      n_err++; $display("FAIL reset_mul got=%h/%h exp=00/00", ifz.mul_a, ifz.mul_b);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] exp_a [4];
    logic [7:0] exp_b [4];
    exp_a = '{8'h34, 8'h12, 8'h34, 8'h12};
    exp_b = '{8'h78, 8'h78, 8'h56, 8'h56};
    start_op(16'h1234, 16'h5678);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (ifz.busy !== 1'b1 || ifz.done !== 1'b0) begin
        n_err++; $display("FAIL basic_busy[%0d] got busy=%b done=%b exp 1/0", i, ifz.busy, ifz.done);
      end
      n_cmp++;
      if (ifz.mul_a !== exp_a[i] || ifz.mul_b !== exp_b[i]) begin
        n_err++; $display("FAIL basic_mul[%0d] got=%h/%h exp=%h/%h", i, ifz.mul_a, ifz.mul_b, exp_a[i], exp_b[i]);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (ifz.done !== 1'b1 || ifz.busy !== 1'b0) begin
      n_err++; $display("FAIL basic_done got done=%b busy=%b exp 1/0", ifz.done, ifz.busy);
    end
    n_cmp++;
    if (ifz.product !== 32'h06260060 || ifn.product !== 32'h06260060) begin
      n_err++; $display("FAIL basic_product got=%h/%h exp=06260060", ifz.product, ifn.product);
    end
    @(negedge clk);
    n_cmp++;
    if (ifz.done !== 1'b0 || ifz.busy !== 1'b0 || ifz.product !== 32'h06260060) begin
      n_err++; $display("FAIL basic_after got done=%b busy=%b prod=%h exp 0/0/06260060", ifz.done, ifz.busy, ifz.product);
    end
  endtask

  task automatic test_random(input int n);
    logic [15:0] a, b;
    logic [31:0] exp_p;
    int          cyc;
    bit          bad;
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        a = 16'hFFFF; b = 16'hFFFF;
      end else begin
        a = 16'($urandom_range(1, 65535));
        b = 16'($urandom_range(1, 65535));
      end
      exp_p = {16'd0, a} * {16'd0, b};
      start_op(a, b);
      cyc = 1;
      bad = 1'b0;
      while (ifz.done !== 1'b1 && cyc < 12) begin
        if (ifz.busy !== 1'b1) bad = 1'b1;
        @(negedge clk);
        cyc++;
      end
      n_cmp++;
      if (cyc != 5) begin
        n_err++; $display("FAIL rand_latency a=%h b=%h got=%0d exp=5", a, b, cyc);
      end
      n_cmp++;
      if (ifz.product !== exp_p || ifn.product !== exp_p) begin
        n_err++; $display("FAIL rand_product a=%h b=%h got=%h/%h exp=%h", a, b, ifz.product, ifn.product, exp_p);
      end
      n_cmp++;
      if (bad || ifz.busy !== 1'b0) begin
        n_err++; $display("FAIL rand_busy a=%h b=%h got gap=%b busy_at_done=%b exp 0/0", a, b, bad, ifz.busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_early_zero();
    int cyc;
    bit z_busy;
    start_op(16'h0000, 16'hABCD);
    n_cmp++;
    if (ifz.done !== 1'b1 || ifz.busy !== 1'b0 || ifz.product !== 32'd0) begin
      n_err++; $display("FAIL ez_fast got done=%b busy=%b prod=%h exp 1/0/0", ifz.done, ifz.busy, ifz.product);
    end
    n_cmp++;
    if (ifn.busy !== 1'b1 || ifn.done !== 1'b0) begin
      n_err++; $display("FAIL ez_off_busy got busy=%b done=%b exp 1/0", ifn.busy, ifn.done);
    end
    cyc = 1;
    z_busy = 1'b0;
    while (ifn.done !== 1'b1 && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (ifz.busy !== 1'b0 || ifz.done !== 1'b0) z_busy = 1'b1;
    end
    n_cmp++;
    if (cyc != 5 || ifn.product !== 32'd0) begin
      n_err++; $display("FAIL ez_off_path got cyc=%0d prod=%h exp 5/0", cyc, ifn.product);
    end
    n_cmp++;
    if (z_busy) begin
      n_err++; $display("FAIL ez_quiet got activity=1 exp=0");
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    set_in(1'b1, 16'h0002, 16'h0003);
    @(negedge clk);
    set_in(1'b1, 16'h0100, 16'h0100);
    cyc = 1;
    while (ifz.done !== 1'b1 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (cyc != 5 || ifz.product !== 32'h00000006) begin
      n_err++; $display("FAIL b2b_first got cyc=%0d prod=%h exp 5/00000006", cyc, ifz.product);
    end
    @(negedge clk);
    set_in(1'b0, 16'h0100, 16'h0100);
    n_cmp++;
    if (ifz.busy !== 1'b1 || ifz.done !== 1'b0) begin
      n_err++; $display("FAIL b2b_no_idle got busy=%b done=%b exp 1/0", ifz.busy, ifz.done);
    end
    cyc = 1;
    while (ifz.done !== 1'b1 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (cyc != 5 || ifz.product !== 32'h00010000 || ifn.product !== 32'h00010000) begin
      n_err++; $display("FAIL b2b_second got cyc=%0d prod=%h/%h exp 5/00010000", cyc, ifz.product, ifn.product);
    end
    @(negedge clk);
    n_cmp++;
    if (ifz.done !== 1'b0 || ifz.busy !== 1'b0) begin
      n_err++; $display("FAIL b2b_pulse got done=%b busy=%b exp 0/0", ifz.done, ifz.busy);
    end
  endtask

  task automatic test_ignore_start();
    logic [15:0] a, b;
    logic [31:0] exp_p;
    int          cyc;
    a = 16'($urandom_range(1, 65535));
    b = 16'($urandom_range(1, 65535));
    exp_p = {16'd0, a} * {16'd0, b};
    start_op(a, b);
    @(negedge clk);
    set_in(1'b1, ~a, 16'h0000);
    @(negedge clk);
    set_in(1'b0, 16'h0000, 16'h0000);
    cyc = 3;
    while (ifz.done !== 1'b1 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (cyc != 5 || ifz.product !== exp_p || ifn.product !== exp_p) begin
      n_err++; $display("FAIL ignore_start got cyc=%0d prod=%h/%h exp 5/%h", cyc, ifz.product, ifn.product, exp_p);
    end
    @(negedge clk);
    n_cmp++;
    if (ifz.busy !== 1'b0 || ifz.done !== 1'b0) begin
      n_err++; $display("FAIL ignore_not_queued got busy=%b done=%b exp 0/0", ifz.busy, ifz.done);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] a, b;
    logic [31:0] exp_p;
    int          cyc;
    bit          saw_done;
    start_op(16'h1234, 16'h5678);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (ifz.product !== 32'h06260060) begin
      n_err++; $display("FAIL rmid_prior got=%h exp=06260060", ifz.product);
    end
    @(negedge clk);
    start_op(16'h1111, 16'h2222);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (ifz.busy !== 1'b0 || ifz.done !== 1'b0 || ifz.product !== 32'd0 || ifn.product !== 32'd0) begin
      n_err++; $display("FAIL rmid_state got busy=%b done=%b prod=%h exp 0/0/0", ifz.busy, ifz.done, ifz.product);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ifz.done !== 1'b0 || ifn.done !== 1'b0 || ifz.busy !== 1'b0) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done) begin
      n_err++; $display("FAIL rmid_no_done got activity=1 exp=0");
    end
    a = 16'($urandom_range(1, 65535));
    b = 16'($urandom_range(1, 65535));
    exp_p = {16'd0, a} * {16'd0, b};
    start_op(a, b);
    cyc = 1;
    while (ifz.done !== 1'b1 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (cyc != 5 || ifz.product !== exp_p) begin
      n_err++; $display("FAIL rmid_fresh got cyc=%0d prod=%h exp 5/%h", cyc, ifz.product, exp_p);
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_random(20);
    test_early_zero();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
